// File: rtl/chacha_block_core.sv
// chacha_block_core: iterative ChaCha block function (state matrix in, keystream block out).
// Default is one round per cycle; defining CHACHA_DBL_ROUND_EN applies a column+diagonal pair per cycle.
module chacha_block_core #(
    parameter int ROUNDS = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0][3:0][31:0] state_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0][3:0][31:0] ks_out,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends only on FSM state, out_ready and rst_n (never on in_valid);
    // ks_out and out_valid stay frozen from assertion until the output transfer.

    if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be even and >= 2");
    end

    localparam int RW = $clog2(ROUNDS + 1);
`ifdef CHACHA_DBL_ROUND_EN
    localparam logic [RW-1:0] RSTEP = RW'(2);
    localparam logic [RW-1:0] RLAST = RW'(ROUNDS - 2);
`else
    localparam logic [RW-1:0] RSTEP = RW'(1);
    localparam logic [RW-1:0] RLAST = RW'(ROUNDS - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    logic [15:0][31:0]  work_q, work_d;
    logic [15:0][31:0]  saved_q, saved_d;
    logic [15:0][31:0]  ks_q, ks_d;
    logic               out_valid_q, out_valid_d;
    logic               accept;

    function automatic logic [127:0] quarter_round(input logic [31:0] a_i, input logic [31:0] b_i,
                                                   input logic [31:0] c_i, input logic [31:0] d_i);
        logic [31:0] a, b, c, d;
        a = a_i;
        b = b_i;
        c = c_i;
        d = d_i;
        a = a + b;  d = d ^ a;  d = {d[15:0], d[31:16]};
        c = c + d;  b = b ^ c;  b = {b[19:0], b[31:20]};
        a = a + b;  d = d ^ a;  d = {d[23:0], d[31:24]};
        c = c + d;  b = b ^ c;  b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Word i of the matrix is row i/4, column i%4; a diagonal round shifts rows 1..3 by 1..3 columns.
    function automatic logic [15:0][31:0] chacha_round(input logic [15:0][31:0] s, input logic diag);
        logic [15:0][31:0] r;
        logic [127:0]      q;
        logic [3:0]        ia, ib, ic, id;
        r = s;
        for (int i = 0; i < 4; i++) begin
            ia = 4'(i);
            ib = 4'd4  + (diag ? 2'(i + 1) : 2'(i));
            ic = 4'd8  + (diag ? 2'(i + 2) : 2'(i));
            id = 4'd12 + (diag ? 2'(i + 3) : 2'(i));
            q = quarter_round(s[ia], s[ib], s[ic], s[id]);
            r[ia] = q[127:96];
            r[ib] = q[95:64];
            r[ic] = q[63:32];
            r[id] = q[31:0];
        end
        return r;
    endfunction

    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign ks_out    = ks_q;
    assign busy      = (state_q == ROUND) || (state_q == ADD);
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        work_d      = work_q;
        saved_d     = saved_q;
        ks_d        = ks_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d  = state_in;
                    saved_d = state_in;
                    rcnt_d  = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
`ifdef CHACHA_DBL_ROUND_EN
                work_d = chacha_round(chacha_round(work_q, 1'b0), 1'b1);
`else
                work_d = chacha_round(work_q, rcnt_q[0]);
`endif
                rcnt_d = rcnt_q + RSTEP;
                if (rcnt_q == RLAST) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < 16; i++) begin
                    ks_d[i] = work_q[i] + saved_q[i];
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        work_d  = state_in;
                        saved_d = state_in;
                        rcnt_d  = '0;
                        state_d = ROUND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rcnt_q      <= '0;
            work_q      <= '0;
            saved_q     <= '0;
            ks_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            work_q      <= work_d;
            saved_q     <= saved_d;
            ks_q        <= ks_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core: known vectors, random blocks, backpressure,
// mid-block reset, back-to-back throughput and a ROUNDS=8 instance.
module tb_chacha_block_core;

    localparam int ROUNDS = 20;
`ifdef CHACHA_DBL_ROUND_EN
    localparam int LAT  = ROUNDS / 2 + 1;
    localparam int LAT8 = 8 / 2 + 1;
`else
    localparam int LAT  = ROUNDS + 1;
    localparam int LAT8 = 8 + 1;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0][3:0][31:0] state_in, ks_out;
    logic [1:0]            dbg_state;
    logic                  in8_valid, in8_ready, out8_valid, out8_ready, busy8;
    logic [3:0][3:0][31:0] state8_in, ks8_out;
    logic [1:0]            dbg8_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [511:0] exp_q[$];
    int           t0_q[$];
    int           rise_q[$];
    logic [511:0] held_ks;
    logic         prev_ov = 1'b0;

    chacha_block_core #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
        .ks_out(ks_out), .busy(busy), .dbg_state(dbg_state)
    );

    chacha_block_core #(.ROUNDS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in8_valid), .in_ready(in8_ready),
        .state_in(state8_in), .out_valid(out8_valid), .out_ready(out8_ready),
        .ks_out(ks8_out), .busy(busy8), .dbg_state(dbg8_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference: the RFC "inner_block" form, column+diagonal pairs over an index table, then add.
    function automatic logic [511:0] ref_block(input logic [511:0] st, input int rounds);
        logic [31:0] x[16];
        logic [31:0] init[16];
        int qi[8][4];
        int a, b, c, d;
        logic [511:0] res;
        qi = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
               '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        for (int i = 0; i < 16; i++) begin
            init[i] = st[32*i +: 32];
            x[i]    = init[i];
        end
        for (int r = 0; r < rounds / 2; r++) begin
            for (int q = 0; q < 8; q++) begin
                a = qi[q][0]; b = qi[q][1]; c = qi[q][2]; d = qi[q][3];
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + init[i];
        return res;
    endfunction

    function automatic logic [511:0] mk_state(input bit rfc_key, input logic [31:0] ctr,
                                              input logic [31:0] n0, input logic [31:0] n1,
                                              input logic [31:0] n2);
        logic [511:0] s;
        s[0*32 +: 32] = 32'h61707865;
        s[1*32 +: 32] = 32'h3320646e;
        s[2*32 +: 32] = 32'h79622d32;
        s[3*32 +: 32] = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            s[(4+i)*32 +: 32] = rfc_key ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : 32'h0;
        end
        s[12*32 +: 32] = ctr;
        s[13*32 +: 32] = n0;
        s[14*32 +: 32] = n1;
        s[15*32 +: 32] = n2;
        return s;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    // scoreboard: expected blocks queued at acceptance, checked when out_valid rises
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            t0_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                rise_q.push_back(cyc - 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got out_valid=1 required no pending block");
                end else begin
                    chk("ks_block", ks_out, exp_q.pop_front());
                    chk("latency", 512'(cyc - 1 - t0_q.pop_front()), 512'(LAT));
                end
                held_ks = ks_out;
            end else if (out_valid && prev_ov) begin
                chk("ks_stable", ks_out, held_ks);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_block(state_in, ROUNDS));
                t0_q.push_back(cyc);
            end
            prev_ov = out_valid;
        end
    end

    // driver tasks (entered #1 after a rising edge)
    task automatic send(input logic [511:0] st, input bit keep);
        int n;
        n = 0;
        in_valid = 1'b1;
        state_in = st;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 required 1 within 300 cycles");
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [511:0] ks);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL out_timeout: got out_valid=0 required 1 within 300 cycles");
        end
        ks = ks_out;
    endtask

    typedef struct {
        logic [511:0] st;
        logic [511:0] exp;
        logic [15:0]  mask;
    } vec_t;

    initial begin
        vec_t vt[2];
        logic [511:0] ks, sa, sb;
        int seen, n, t0;

        vt[0].st   = mk_state(1'b1, 32'd1, 32'h09000000, 32'h4a000000, 32'h0);
        vt[0].exp  = '0;
        vt[0].exp[0*32 +: 32]  = 32'he4e7f110;
        vt[0].exp[1*32 +: 32]  = 32'h15593bd1;
        vt[0].exp[2*32 +: 32]  = 32'h1fdd0f50;
        vt[0].exp[3*32 +: 32]  = 32'hc47120a3;
        vt[0].exp[15*32 +: 32] = 32'h4e3c50a2;
        vt[0].mask = 16'h800f;
        vt[1].st   = mk_state(1'b0, 32'd0, 32'h0, 32'h0, 32'h0);
        vt[1].exp  = '0;
        vt[1].exp[0*32 +: 32]  = 32'hade0b876;
        vt[1].mask = 16'h0001;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; state_in = '0;
        in8_valid = 1'b0; out8_ready = 1'b1; state8_in = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(0));
        chk("rst_ks_out", ks_out, 512'(0));
        chk("rst_state", 512'(dbg_state), 512'(0));
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 512'(in_ready), 512'(1));

        // known vectors
        for (int v = 0; v < 2; v++) begin
            send(vt[v].st, 1'b0);
            wait_out(ks);
            for (int w = 0; w < 16; w++) begin
                if (vt[v].mask[w]) chk("vec_word", 512'(ks[32*w +: 32]), 512'(vt[v].exp[32*w +: 32]));
            end
            @(posedge clk); #1;
        end

        // random blocks with random output stalls
        for (int k = 0; k < 6; k++) begin
            send(rand_state(), 1'b0);
            wait_out(ks);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end

        // backpressure; in_valid stays high with another state while busy
        sa = rand_state();
        sb = rand_state();
        out_ready = 1'b0;
        send(sa, 1'b1);
        state_in = sb;
        wait_out(ks);
        for (int k = 0; k < 10; k++) begin
            chk("bp_in_ready", 512'(in_ready), 512'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 512'(in_ready), 512'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_reaccept_busy", 512'(busy), 512'(1));
        chk("bp_out_cleared", 512'(out_valid), 512'(0));
        wait_out(ks);
        @(posedge clk); #1;

        // reset in the middle of a block
        send(rand_state(), 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 512'(out_valid), 512'(0));
        chk("mid_rst_ks_out", ks_out, 512'(0));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", 512'(in_ready), 512'(1));
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abandoned_no_output", 512'(seen), 512'(0));

        // back-to-back blocks, counters 1..4
        rise_q.delete();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            send(mk_state(1'b1, 32'(k), 32'h09000000, 32'h4a000000, 32'h0), 1'b1);
        end
        in_valid = 1'b0;
        n = 0;
        while (rise_q.size() < 4 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_count", 512'(rise_q.size()), 512'(4));
        for (int i = 1; i < 4 && i < rise_q.size(); i++) begin
            chk("b2b_spacing", 512'(rise_q[i] - rise_q[i-1]), 512'(LAT + 1));
        end
        repeat (2) begin @(posedge clk); #1; end

        // ROUNDS=8 instance with the RFC vector
        chk("r8_in_ready", 512'(in8_ready), 512'(1));
        in8_valid = 1'b1;
        state8_in = vt[0].st;
        @(posedge clk); #1;
        t0 = cyc;
        in8_valid = 1'b0;
        n = 0;
        while (!out8_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("r8_latency", 512'(cyc - t0), 512'(LAT8));
        chk("r8_block", ks8_out, ref_block(vt[0].st, 8));
        @(posedge clk); #1;

        chk("pending_empty", 512'(exp_q.size()), 512'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chacha_block_core.md
Name: chacha_block_core

Overview:
- Consumes the 4x4 initial ChaCha20 state matrix from the state-builder stage and produces one 512-bit keystream block.
- The keystream block is the working state after ROUNDS rounds, added word-wise (mod 2^32) to the saved initial state.
- Iterative datapath: four parallel quarter-rounds per cycle, i.e. one column or diagonal round per cycle.
- Valid/ready handshake on both sides; feeds the downstream XOR/Poly1305 key stage.

Parameters:
- ROUNDS, 20, total rounds. Must be even and >= 2; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a new state
- state_in  input  word_t [3:0][3:0]  initial matrix; [r][c] is word 4r+c
- out_valid  output  1  ks_out holds a finished block
- out_ready  input  1  downstream accepts ks_out
- ks_out  output  word_t [3:0][3:0]  keystream matrix, same indexing
- busy  output  1  high in ROUND or ADD

Behaviour:
- Reset is synchronous and active-low on rst_n; single clock clk.
- While rst_n=0 at a clk edge, all of the following are zero: FSM=IDLE, round counter, working state, saved state, ks_out, out_valid, busy.
- in_ready is 1 in IDLE, and 0 during reset.
- FSM states:
  - IDLE: in_valid&in_ready loads state_in into the working and saved registers, clears rcnt, goes to ROUND.
  - ROUND: each cycle applies one round to the working state. Even rcnt is a column round, QR on words (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15). Odd rcnt is a diagonal round, QR on (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14). rcnt increments each cycle. When rcnt==ROUNDS-1, go to ADD.
  - ADD: ks_out[i] <= working[i]+saved[i] mod 2^32; out_valid<=1; go to DONE.
  - DONE: hold ks_out and out_valid stable until out_valid&out_ready. On that handshake, clear out_valid. If in_valid is also high, accept the new state_in that same edge and go to ROUND; otherwise go to IDLE.
- in_ready is combinational: (IDLE) || (DONE && out_ready). No combinational path from in_valid to in_ready.
- Quarter-round QR(a,b,c,d), all 32-bit with carries dropped, rotations left:
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
- Latency: acceptance edge T0; out_valid rises at edge T0+ROUNDS+1 (21 for the default).
- Throughput is one block per ROUNDS+2 cycles when out_ready is held high.
- in_valid while busy: ignored, not latched. state_in is sampled only on the acceptance edge.
- Reset mid-operation: the block is abandoned and no partial output appears.
- rcnt width is $clog2(ROUNDS+1). It does not wrap within a block and is cleared on every acceptance.
- busy = (ROUND||ADD).

Optional Feature:
- Macro: CHACHA_DBL_ROUND_EN.
- Defined: each ROUND cycle applies a column round followed by a diagonal round (8 QRs chained combinationally). rcnt advances by 2, and ADD is entered when rcnt==ROUNDS-2.
- Defined, latency: out_valid rises at T0+ROUNDS/2+1 (11 for the default).
- Not defined: one round per cycle as above.
- Handshake, ordering and results are identical either way.

Test Plan:
- RFC 8439 2.3.2 vector (constants 61707865 3320646e 79622d32 6b206574; key 03020100..1f1e1d1c; counter 1; nonce 09000000 4a000000 00000000), out_ready=1:
  - ks_out words 0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3; word 15 = 4e3c50a2.
  - out_valid at T0+21 (T0+11 with CHACHA_DBL_ROUND_EN).
- All-zero key/nonce/counter with standard constants -> ks_out[0][0] = ade0b876.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> ks_out stable, in_ready=0, a new in_valid is ignored; then out_ready=1 with in_valid=1 -> handshake and new acceptance on the same edge, second block correct.
- rst_n=0 for 1 cycle at T0+7 -> next edge: out_valid=0, ks_out=0, busy=0, in_ready=1; no output ever appears for the abandoned block.
- Back-to-back: 4 blocks with counters 1..4, in_valid and out_ready held high -> 4 outputs in order, spaced 22 cycles apart, each matching the reference model.
- ROUNDS=8 elaboration with the RFC vector -> output matches the ChaCha8 model; out_valid at T0+9.
